// File: rtl/ram_rw_arbiter_pkg.sv
// Shared types and defaults for the two-requester block-RAM arbiter.
// Owner encoding is used by both the arbitration logic and the read tag pipe.
package ram_rw_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned RD_LAT_DEF = 2;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

    // Returns {pick_b, pick_a}; on a tie the requester that did not own the port last wins.
    function automatic logic [1:0] arb_pick(
        input logic   elig_a,
        input logic   elig_b,
        input owner_e last_owner
    );
        logic pick_a;
        logic pick_b;
        pick_a = elig_a & (~elig_b | (last_owner == OWNER_B));
        pick_b = elig_b & ~pick_a;
        return {pick_b, pick_a};
    endfunction

endpackage

// File: rtl/ram_rw_arbiter_rd_tag_pipe.sv
// Delay line carrying {valid, owner} for each granted read through the RAM read latency.
// Cleared asynchronously so that reads in flight at reset never return.
module rd_tag_pipe
    import ram_rw_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = RD_LAT_DEF
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/ram_rw_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM between requesters A and B.
// Grants and the RAM port are registered together; read data is routed back to its owner.
module ram_rw_arbiter
    import ram_rw_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,

    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,

    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    logic              r_gnt_a;
    logic              r_gnt_b;
    owner_e            r_last_owner;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;
    logic              r_rvalid_a;
    logic              r_rvalid_b;
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;

    logic              w_elig_a;
    logic              w_elig_b;
    logic [1:0]        w_pick;
    logic              w_pick_a;
    logic              w_pick_b;
    rd_tag_t           w_tag_in;
    rd_tag_t           w_tag_out;

    // A requester still showing its grant is masked, since its req may not have dropped yet.
    assign w_elig_a = req_a & ~r_gnt_a;
    assign w_elig_b = req_b & ~r_gnt_b;
    assign w_pick   = arb_pick(w_elig_a, w_elig_b, r_last_owner);
    assign w_pick_a = w_pick[0];
    assign w_pick_b = w_pick[1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_gnt_a      <= 1'b0;
            r_gnt_b      <= 1'b0;
            r_last_owner <= OWNER_B;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
        end else begin
            r_gnt_a  <= w_pick_a;
            r_gnt_b  <= w_pick_b;
            r_ram_en <= w_pick_a | w_pick_b;
            if (w_pick_a) begin
                r_ram_we     <= we_a;
                r_ram_addr   <= addr_a;
                r_ram_din    <= wdata_a;
                r_last_owner <= OWNER_A;
            end else if (w_pick_b) begin
                r_ram_we     <= we_b;
                r_ram_addr   <= addr_b;
                r_ram_din    <= wdata_b;
                r_last_owner <= OWNER_B;
            end else begin
                r_ram_we <= 1'b0;
            end
        end
    end

    // The cycle the RAM port carries a read is the cycle its tag enters the pipe.
    assign w_tag_in.valid = r_ram_en & ~r_ram_we;
    assign w_tag_in.owner = r_gnt_b ? OWNER_B : OWNER_A;

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
        end else begin
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            if (w_tag_out.valid) begin
                if (w_tag_out.owner == OWNER_A) begin
                    r_rvalid_a <= 1'b1;
                    r_rdata_a  <= ram_dout;
                end else begin
                    r_rvalid_b <= 1'b1;
                    r_rdata_b  <= ram_dout;
                end
            end
        end
    end

    assign gnt_a    = r_gnt_a;
    assign gnt_b    = r_gnt_b;
    assign ram_en   = r_ram_en;
    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;
    assign rdata_a  = r_rdata_a;
    assign rdata_b  = r_rdata_b;

endmodule

// File: tb/tb_ram_rw_arbiter.sv
// Directed bench for ram_rw_arbiter with a behavioural 2-cycle-latency write-first RAM.
module tb_ram_rw_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst_n;
    logic          req_a, we_a, req_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    int unsigned n_total;
    int unsigned n_bad;

    ram_rw_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_LAT (2)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .req_a     (req_a),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .wdata_a   (wdata_a),
        .gnt_a     (gnt_a),
        .rvalid_a  (rvalid_a),
        .rdata_a   (rdata_a),
        .req_b     (req_b),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .wdata_b   (wdata_b),
        .gnt_b     (gnt_b),
        .rvalid_b  (rvalid_b),
        .rdata_b   (rdata_b),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: dout valid two cycles after the enable cycle, write-first.
    logic [DW-1:0] mem [32];
    logic [DW-1:0] rd0, rd1;
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rd0 = '0;
        rd1 = '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_din;
                rd0 <= ram_din;
            end else begin
                rd0 <= mem[ram_addr];
            end
        end
        rd1 <= rd0;
    end
    assign ram_dout = rd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {26'd0, gnt_a, gnt_b, rvalid_a, rvalid_b, ram_en, ram_we}, 32'd0);
        chk({tag, "_addr"}, {27'd0, ram_addr}, 32'd0);
        chk({tag, "_din"}, {24'd0, ram_din}, 32'd0);
        chk({tag, "_rdata"}, {16'd0, rdata_a, rdata_b}, 32'd0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        idle_inputs();
        rst_n = 0;

        // 1. reset with random inputs
        for (int i = 0; i < 3; i++) begin
            req_a = 1'($urandom); we_a = 1'($urandom); addr_a = AW'($urandom); wdata_a = DW'($urandom);
            req_b = 1'($urandom); we_b = 1'($urandom); addr_b = AW'($urandom); wdata_b = DW'($urandom);
            tick();
            chk_all_zero("rst");
        end
        idle_inputs();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_quiet", {28'd0, gnt_a, gnt_b, rvalid_a, rvalid_b}, 32'd0);
        end

        // 2. A writes 0x5A to addr 3, then reads it back
        req_a = 1; we_a = 1; addr_a = 5'd3; wdata_a = 8'h5A;
        tick();
        chk("t2_wr_gnt", {29'd0, gnt_a, gnt_b, ram_en}, 32'b101);
        chk("t2_wr_we", {31'd0, ram_we}, 32'd1);
        chk("t2_wr_addr", {27'd0, ram_addr}, 32'd3);
        chk("t2_wr_din", {24'd0, ram_din}, 32'h5A);
        we_a = 0;
        tick();
        chk("t2_mask", {30'd0, gnt_a, ram_en}, 32'd0);
        tick();
        chk("t2_rd_gnt", {29'd0, gnt_a, ram_en, ram_we}, 32'b110);
        req_a = 0;
        tick();
        tick();
        chk("t2_rv_early", {31'd0, rvalid_a}, 32'd0);
        tick();
        chk("t2_rv", {30'd0, rvalid_a, rvalid_b}, 32'b10);
        chk("t2_rdata", {24'd0, rdata_a}, 32'h5A);
        tick();
        chk("t2_rv_pulse", {31'd0, rvalid_a}, 32'd0);
        chk("t2_rdata_hold", {24'd0, rdata_a}, 32'h5A);

        // 3. both requesting continuously, fresh pointer => A,B,A,B...
        rst_n = 0;
        tick();
        rst_n = 1;
        req_a = 1; addr_a = 5'd4; req_b = 1; addr_b = 5'd5;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_gnt", {30'd0, gnt_a, gnt_b}, (i % 2 == 0) ? 32'b10 : 32'b01);
            chk("t3_en", {31'd0, ram_en}, 32'd1);
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) tick();

        // 4. same-cycle A read / B write to addr 1 (preloaded with 0x11)
        req_b = 1; we_b = 1; addr_b = 5'd1; wdata_b = 8'h11;
        tick();
        chk("t4_pre_gnt", {30'd0, gnt_a, gnt_b}, 32'b01);
        req_b = 0;
        tick();
        req_a = 1; we_a = 0; addr_a = 5'd1;
        req_b = 1; we_b = 1; addr_b = 5'd1; wdata_b = 8'h22;
        tick();
        chk("t4_gnt_first", {29'd0, gnt_a, gnt_b, ram_we}, 32'b100);
        req_a = 0;
        tick();
        chk("t4_gnt_second", {29'd0, gnt_a, gnt_b, ram_we}, 32'b011);
        chk("t4_din", {24'd0, ram_din}, 32'h22);
        req_b = 0;
        tick();
        tick();
        chk("t4_rv_old", {30'd0, rvalid_a, rvalid_b}, 32'b10);
        chk("t4_rdata_old", {24'd0, rdata_a}, 32'h11);
        req_a = 1; we_a = 0; addr_a = 5'd1;
        tick();
        chk("t4_gnt_rd2", {30'd0, gnt_a, ram_we}, 32'b10);
        req_a = 0;
        tick();
        tick();
        tick();
        chk("t4_rv_new", {31'd0, rvalid_a}, 32'd1);
        chk("t4_rdata_new", {24'd0, rdata_a}, 32'h22);

        // 5. only A requesting continuously => grant every other cycle
        tick();
        req_a = 1; we_a = 1; addr_a = 5'd31; wdata_a = 8'h77;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5_gnt", {30'd0, gnt_a, ram_en}, (i % 2 == 0) ? 32'b11 : 32'b00);
        end
        idle_inputs();
        tick();
        chk("t5_stop", {31'd0, ram_en}, 32'd0);

        // 6. reset one cycle after a read grant discards the read
        req_a = 1; we_a = 0; addr_a = 5'd3;
        tick();
        chk("t6_gnt", {29'd0, gnt_a, ram_en, ram_we}, 32'b110);
        req_a = 0;
        tick();
        rst_n = 0;
        #1;
        chk_all_zero("t6_rst");
        tick();
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_no_rv", {30'd0, rvalid_a, rvalid_b}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
